// File: rtl/hex_token_fsm.sv
// Recogniser for delimited hexadecimal tokens in the classified-character stream.
// Accumulates MIN_LEN..MAX_LEN hex digits between two NUL delimiters, with an optional 0x/0X prefix.
module hex_token_fsm #(
   parameter int MIN_LEN      = 8,
   parameter int MAX_LEN      = 8,
   parameter int ALLOW_PREFIX = 0,
   parameter int LOWER_OK     = 1,
   parameter int CNT_W        = $clog2(MAX_LEN + 1),
   parameter int VW           = 4 * MAX_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [7:0]       char,
   input  logic             start_stop,
   input  logic             hex_digit,
   input  logic             error_verify,
   output logic [2:0]       state,
   output logic             done,
   output logic             err,
   output logic [VW-1:0]    value,
   output logic [CNT_W-1:0] len,
   output logic             busy
);

   // state  | meaning
   // IDLE   | waiting for the leading NUL of a token
   // START  | leading NUL seen, value/len cleared, expecting first digit
   // STOP   | token accepted; done is high for this single cycle
   // ERROR  | token rejected; term says whether a delimiter caused it
   // DIGIT  | accumulating hex digits
   // PFX0   | first digit was '0' and a prefix is allowed; acts as DIGIT
   // PFX_X  | 0x/0X prefix consumed, expecting first real digit
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_STOP  = 3'd2,
      S_ERROR = 3'd3,
      S_DIGIT = 3'd4,
      S_PFX0  = 3'd5,
      S_PFX_X = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

   state_t           cur_state;
   state_t           nxt_state;
   logic [VW-1:0]    value_q;
   logic [VW-1:0]    nxt_value;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] nxt_len;
   logic             term_q;
   logic             nxt_term;
   logic             err_q;

   logic             is_lower;
   logic             is_x;
   logic             is_hex;
   logic             is_zero;
   logic             take_digit;
   logic [3:0]       nib;
   logic [VW-1:0]    shifted;

   assign is_lower = (char >= 8'h61) && (char <= 8'h66);
   assign is_x     = (char == 8'h78) || (char == 8'h58);
   assign is_zero  = (char == 8'h30);
   // A delimiter always takes priority over a hex flag on the same character.
   assign is_hex   = hex_digit && !start_stop && ((LOWER_OK != 0) || !is_lower);

   // Letters A-F / a-f all carry 1..6 in the low nibble; digits carry their value directly.
   assign nib = char[6] ? (char[3:0] + 4'd9) : char[3:0];

   generate
      if (VW > 4) begin : g_shift_wide
         assign shifted = {value_q[VW-5:0], nib};
      end else begin : g_shift_one
         assign shifted = nib;
      end
   endgenerate

   always_comb begin
      nxt_state  = cur_state;
      nxt_value  = value_q;
      nxt_len    = len_q;
      nxt_term   = term_q;
      take_digit = 1'b0;

      case (cur_state)
         S_IDLE: begin
            if (valid && start_stop) begin
               nxt_state = S_START;
               nxt_value = '0;
               nxt_len   = '0;
            end
         end

         S_START: begin
            if (valid) begin
               if (start_stop) begin
                  nxt_state = S_ERROR;
                  nxt_term  = 1'b1;
               end else if (is_hex) begin
                  take_digit = 1'b1;
                  nxt_state  = ((ALLOW_PREFIX != 0) && is_zero) ? S_PFX0 : S_DIGIT;
               end else begin
                  nxt_state = S_ERROR;
                  nxt_term  = 1'b0;
               end
            end
         end

         S_PFX_X: begin
            if (valid) begin
               if (start_stop) begin
                  nxt_state = S_ERROR;
                  nxt_term  = 1'b1;
               end else if (is_hex) begin
                  take_digit = 1'b1;
                  nxt_state  = S_DIGIT;
               end else begin
                  nxt_state = S_ERROR;
                  nxt_term  = 1'b0;
               end
            end
         end

         S_DIGIT, S_PFX0: begin
            if (valid) begin
               if (start_stop) begin
                  if (len_q >= MIN_CNT) begin
                     nxt_state = S_STOP;
                  end else begin
                     nxt_state = S_ERROR;
                     nxt_term  = 1'b1;
                  end
               end else if (is_hex) begin
                  if (len_q < MAX_CNT) begin
                     take_digit = 1'b1;
                     nxt_state  = S_DIGIT;
                  end else begin
                     nxt_state = S_ERROR;
                     nxt_term  = 1'b0;
                  end
               end else if ((cur_state == S_PFX0) && is_x) begin
                  // The leading '0' was a prefix, not a digit.
                  nxt_state = S_PFX_X;
                  nxt_value = '0;
                  nxt_len   = '0;
               end else begin
                  nxt_state = S_ERROR;
                  nxt_term  = 1'b0;
               end
            end
         end

         S_STOP: begin
            nxt_state = S_IDLE;
         end

         S_ERROR: begin
            if (error_verify || term_q || (valid && start_stop)) begin
               nxt_state = S_IDLE;
            end
         end

         default: begin
            nxt_state = S_IDLE;
         end
      endcase

      if (take_digit) begin
         nxt_value = shifted;
         nxt_len   = len_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_IDLE;
         value_q   <= '0;
         len_q     <= '0;
         term_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         value_q   <= nxt_value;
         len_q     <= nxt_len;
         term_q    <= nxt_term;
         err_q     <= (nxt_state == S_ERROR) && (cur_state != S_ERROR);
      end
   end

   assign state = cur_state;
   assign done  = (cur_state == S_STOP);
   assign busy  = (cur_state != S_IDLE);
   assign err   = err_q;
   assign value = value_q;
   assign len   = len_q;

endmodule

// File: doc/hex_token_fsm.md
# hex_token_fsm

Parametrised recogniser for delimited hexadecimal tokens in the classified-character stream. It owns its state register, so no external next_state feedback loop is needed. It accepts a token of MIN_LEN..MAX_LEN hex digits between two `\0` delimiters, with an optional `0x`/`0X` prefix. It outputs the decoded numeric value, the digit count, a one-cycle `done` pulse and a one-cycle `err` pulse. It sits directly after the character classifier and replaces the fixed-length per-variant hex checker.

## Interface
- MIN_LEN, 8, minimum accepted digit count (1 ≤ MIN_LEN ≤ MAX_LEN).
- MAX_LEN, 8, maximum accepted digit count (≤ 16).
- ALLOW_PREFIX, 0, 1 = a leading `0x`/`0X` is accepted and not counted as digits.
- LOWER_OK, 1, 0 = `a`–`f` are rejected as non-hex.
- Derived: CNT_W = $clog2(MAX_LEN+1); VW = 4*MAX_LEN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  a character is presented this cycle.
- char  in  8  raw ASCII character, used for nibble decode and `0`/`x`/`X` detection.
- start_stop  in  1  classifier flag: char is `\0`.
- hex_digit  in  1  classifier flag: char is in 0-9 / A-F / a-f.
- error_verify  in  1  external acknowledge; forces ERROR→IDLE.
- state  out  3  current state (encoding below).
- done  out  1  high for the single cycle spent in STOP.
- err  out  1  one-cycle pulse on the cycle state first reads ERROR.
- value  out  VW  accumulated value, most recent digit in bits [3:0].
- len  out  CNT_W  digits accumulated.
- busy  out  1  state ≠ IDLE.

## Operation
- State encoding: IDLE=0, START=1, STOP=2, ERROR=3, DIGIT=4, PFX0=5, PFX_X=6.
- A character is consumed only when valid=1. STOP and ERROR (terminated case) also advance without valid.
- "hex" means hex_digit=1 AND (LOWER_OK=1 OR char ∉ `a`–`f`).
- Nibble decode:
  - `0`–`9` → char−0x30.
  - `A`–`F` → char−0x37.
  - `a`–`f` → char−0x57.
- Shift in a digit: value ← {value[VW-5:0], nib}; len ← len+1.
- IDLE: start_stop → START; all other characters are ignored.
- START: clears value and len to 0 on entry.
  - hex with ALLOW_PREFIX=1 and char=`0` → PFX0, shift digit.
  - Any other hex → DIGIT, shift digit.
  - start_stop (empty token) → ERROR, terminated.
  - Anything else → ERROR, in-string.
- PFX0: behaves as DIGIT. Additionally, `x`/`X` → PFX_X with value and len cleared to 0.
- PFX_X:
  - hex → DIGIT, shift digit.
  - start_stop → ERROR, terminated.
  - Anything else → ERROR, in-string.
- DIGIT:
  - hex with len < MAX_LEN → DIGIT, shift digit.
  - hex with len = MAX_LEN → ERROR, in-string.
  - start_stop with len ≥ MIN_LEN → STOP.
  - start_stop with len < MIN_LEN → ERROR, terminated.
  - Anything else → ERROR, in-string.
- STOP: → IDLE next cycle unconditionally. value and len hold until the next START entry.
- ERROR:
  - Internal flag `term` records whether the error was caused by a delimiter.
  - term=1 → IDLE next cycle. This avoids waiting for a second `\0`.
  - term=0 → stay until valid & start_stop, then IDLE.
  - error_verify=1 → IDLE next cycle in either case.
- error_verify is ignored outside ERROR.
- The delimiter that ends a token is consumed. A following token needs its own leading `\0` (IDLE → START).

## Timing
- Async reset: state=IDLE, value=0, len=0, done=0, err=0, busy=0, term=0, all immediately and independent of clk.
- Reset asserted mid-token aborts the token. No done/err is produced.
- Latency from the edge consuming the terminating `\0`:
  - The next cycle shows state=STOP and done=1.
  - The following cycle shows IDLE and done=0.
- err is registered together with the transition into ERROR. It is never high two cycles in a row.
- value and len update on the same edge as the state transition that shifts the digit.
- Simultaneous start_stop and hex_digit cannot occur; if they do, start_stop wins.
- len never exceeds MAX_LEN. No wrap-around is possible.
- valid=0 in any state other than STOP or terminated ERROR holds all registers.

## Test plan
- Defaults; stream `\0 1 2 A b C d E f \0`:
  - done pulses once with value=0x12ABCDEF, len=8.
  - state returns to IDLE one cycle later.
- Defaults; 9 digits `\0 123456789`:
  - err pulses on the 9th digit.
  - The FSM stays in ERROR until the next valid `\0`, then goes to IDLE.
- MIN_LEN=2, MAX_LEN=4, ALLOW_PREFIX=1:
  - `\0 0x3F \0` → done, value=0x003F, len=2.
  - `\0 0 \0` → err (len 1 < 2), then IDLE on the next clock without a further `\0`.
- LOWER_OK=0; `\0 AB cd \0` → err on `c`. `\0 \0` (empty token) → err with terminated exit.
- Reset and external abort:
  - Assert rst asynchronously mid-token → all outputs zero immediately.
  - In in-string ERROR, pulse error_verify → IDLE on the next edge with no `\0`.
- valid gaps: hold valid=0 for 3 cycles between digits → state, value and len are unchanged, and the final result equals the no-gap run.
